// File: rtl/stierlitz_ramdisk.sv
// Byte-wide RAM disk target on the stierlitz control bus: 2^SECTORS_LOG2 sectors x 512 bytes.
// Latency: op accepted at edge T, bus_ready low after T and T+1, high and read data valid after T+2 (one op per 3 cycles).
// Backpressure: bus_ready=0 while an op is in flight; bus_start_op is ignored (not queued) while busy.
//
// Ports: clk, resetn (sync, active-low); bus_address[40:9]=LBA, [8:0]=byte offset;
//        bus_data (inout, driven with rdata while bus_rw=0); bus_rw (1=write); bus_start_op;
//        bus_ready; range_err (sticky, LBA out of range); activity (stretched op-done LED).
// Optional: `define RAMDISK_WRITE_PROTECT_EN adds input write_protect and output wp_hits[15:0].

module stierlitz_ramdisk #(
    parameter int SECTORS_LOG2 = 6,
    parameter int ACT_STRETCH  = 1000000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        bus_ready,
    input  logic [40:0] bus_address,
    inout  wire  [7:0]  bus_data,
    input  logic        bus_rw,
    input  logic        bus_start_op,
    output logic        range_err,
    output logic        activity
`ifdef RAMDISK_WRITE_PROTECT_EN
    ,
    input  logic        write_protect,
    output logic [15:0] wp_hits
`endif
);

    localparam int AW    = SECTORS_LOG2 + 9;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = (ACT_STRETCH > 1) ? $clog2(ACT_STRETCH) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_ready;
    logic [40:0]    r_addr;
    logic           r_rw;
    logic [7:0]     r_wdata;
    logic [7:0]     r_rdata;
    logic           r_range_err;
    logic           r_act;
    logic [CW-1:0]  r_act_cnt;
    logic [7:0]     r_ram_q;
    logic [7:0]     r_mem [DEPTH];

    logic [31:0]    w_lba;
    logic           w_oor;
    logic [AW-1:0]  w_idx;
    logic           w_wp_block;
    logic           w_wr_en;

    assign w_lba = r_addr[40:9];
    // Full 32-bit LBA compare: any set bit at or above SECTORS_LOG2 is out of range,
    // so large LBAs never alias onto low sectors.
    assign w_oor = (w_lba >> SECTORS_LOG2) != 32'd0;
    assign w_idx = {w_lba[SECTORS_LOG2-1:0], r_addr[8:0]};

`ifdef RAMDISK_WRITE_PROTECT_EN
    logic [15:0] r_wp_hits;
    assign w_wp_block = write_protect;
    assign wp_hits    = r_wp_hits;
`else
    assign w_wp_block = 1'b0;
`endif

    // resetn gates the commit so a write caught in ACCESS by a reset edge is abandoned.
    assign w_wr_en = resetn && (r_state == ACCESS) && r_rw && !w_oor && !w_wp_block;

    // Block RAM: no reset on the array, registered read port.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= r_wdata;
        end
        r_ram_q <= r_mem[w_idx];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_wdata     <= 8'h00;
            r_rdata     <= 8'h00;
            r_range_err <= 1'b0;
            r_act       <= 1'b0;
            r_act_cnt   <= '0;
`ifdef RAMDISK_WRITE_PROTECT_EN
            r_wp_hits   <= 16'h0000;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus_start_op) begin
                        r_addr  <= bus_address;
                        r_rw    <= bus_rw;
                        if (bus_rw) begin
                            r_wdata <= bus_data;
                        end
                        r_ready <= 1'b0;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_oor) begin
                        r_range_err <= 1'b1;
                    end
`ifdef RAMDISK_WRITE_PROTECT_EN
                    // Only writes that would otherwise have landed count as blocked.
                    if (r_rw && !w_oor && write_protect && (r_wp_hits != 16'hFFFF)) begin
                        r_wp_hits <= r_wp_hits + 16'd1;
                    end
`endif
                    r_state <= COMPLETE;
                end
                COMPLETE: begin
                    if (!r_rw) begin
                        r_rdata <= w_oor ? 8'h00 : r_ram_q;
                    end
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase

            // Activity stretch: COMPLETE is the op-done event; count down only while idle.
            if (r_state == COMPLETE) begin
                r_act     <= 1'b1;
                r_act_cnt <= CW'(ACT_STRETCH - 1);
            end else if (r_state == IDLE) begin
                if (r_act_cnt != '0) begin
                    r_act_cnt <= r_act_cnt - CW'(1);
                end else begin
                    r_act <= 1'b0;
                end
            end
        end
    end

    assign bus_ready = r_ready;
    assign range_err = r_range_err;
    assign activity  = r_act;
    assign bus_data  = bus_rw ? 8'hzz : r_rdata;

endmodule

// File: tb/tb_stierlitz_ramdisk.sv
// Self-checking bench for stierlitz_ramdisk with SECTORS_LOG2=6, ACT_STRETCH=8.
// Read expectations come from a byte model and are queued at issue, popped when bus_ready returns.
// Handshake timing, busy/back-to-back behaviour, range errors, mid-op reset and activity stretch.

module tb_stierlitz_ramdisk;

    logic        clk = 1'b0;
    logic        resetn;
    wire         bus_ready;
    logic [40:0] bus_address;
    wire  [7:0]  bus_data;
    logic        bus_rw;
    logic        bus_start_op;
    wire         range_err;
    wire         activity;
    logic [7:0]  tb_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] model [int];
    logic [7:0] exp_q [$];

    assign bus_data = bus_rw ? tb_wdata : 8'hzz;

`ifdef RAMDISK_WRITE_PROTECT_EN
    logic        write_protect;
    wire  [15:0] wp_hits;
`endif

    stierlitz_ramdisk #(.SECTORS_LOG2(6), .ACT_STRETCH(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus_ready    (bus_ready),
        .bus_address  (bus_address),
        .bus_data     (bus_data),
        .bus_rw       (bus_rw),
        .bus_start_op (bus_start_op),
        .range_err    (range_err),
        .activity     (activity)
`ifdef RAMDISK_WRITE_PROTECT_EN
        ,
        .write_protect(write_protect),
        .wp_hits      (wp_hits)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int midx(input logic [31:0] lba, input logic [8:0] off);
        return int'({lba[5:0], off});
    endfunction

    // Compute the expected read value from the model and queue it.
    task automatic push_read(input logic [31:0] lba, input logic [8:0] off);
        if (lba >= 32'd64) exp_q.push_back(8'h00);
        else if (model.exists(midx(lba, off))) exp_q.push_back(model[midx(lba, off)]);
        else exp_q.push_back(8'hxx);
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) check_eq({tag, "_sb_underflow"}, 32'd0, 32'd1);
        else check_eq(tag, {24'd0, bus_data}, {24'd0, exp_q.pop_front()});
    endtask

    // One complete op starting from posedge+1 in IDLE; checks the 3-cycle handshake.
    task automatic do_op(input string tag, input logic rw, input logic [31:0] lba,
                         input logic [8:0] off, input logic [7:0] wd);
        bus_address  = {lba, off};
        bus_rw       = rw;
        tb_wdata     = wd;
        bus_start_op = 1'b1;
        if (!rw) push_read(lba, off);
        else if (lba < 32'd64) model[midx(lba, off)] = wd;
        tick();
        bus_start_op = 1'b0;
        check_eq({tag, "_rdy_t1"}, {31'd0, bus_ready}, 32'd0);
        tick();
        check_eq({tag, "_rdy_t2"}, {31'd0, bus_ready}, 32'd0);
        tick();
        check_eq({tag, "_rdy_t3"}, {31'd0, bus_ready}, 32'd1);
        if (!rw) pop_check({tag, "_data"});
    endtask

    task automatic apply_reset(input int n);
        resetn = 1'b0;
        repeat (n) tick();
        resetn = 1'b1;
    endtask

    initial begin
        int ops, hi;
        logic prev_rdy;
        logic act_min;

        resetn       = 1'b0;
        bus_address  = '0;
        bus_rw       = 1'b0;
        bus_start_op = 1'b1;
        tb_wdata     = 8'h00;
`ifdef RAMDISK_WRITE_PROTECT_EN
        write_protect = 1'b0;
`endif
        // Reset with start_op held high: nothing may start.
        repeat (4) tick();
        check_eq("rst_ready", {31'd0, bus_ready}, 32'd1);
        check_eq("rst_range_err", {31'd0, range_err}, 32'd0);
        check_eq("rst_activity", {31'd0, activity}, 32'd0);
        check_eq("rst_bus_data", {24'd0, bus_data}, 32'd0);
        bus_start_op = 1'b0;
        resetn = 1'b1;
        tick();
        check_eq("rst_no_op", {31'd0, bus_ready}, 32'd1);

        // Write then read back, plus seed locations used later.
        do_op("wr_a5", 1'b1, 32'd3, 9'h1FF, 8'hA5);
        do_op("rd_a5", 1'b0, 32'd3, 9'h1FF, 8'h00);
        do_op("wr_lba0", 1'b1, 32'd0, 9'h000, 8'h11);
        do_op("wr_lba63", 1'b1, 32'd63, 9'h000, 8'h63);
        do_op("rd_lba63", 1'b0, 32'd63, 9'h000, 8'h00);
        check_eq("lba63_no_range_err", {31'd0, range_err}, 32'd0);

        // start_op pulsed while busy is ignored.
        bus_address  = {32'd3, 9'h1FF};
        bus_rw       = 1'b0;
        bus_start_op = 1'b1;
        push_read(32'd3, 9'h1FF);
        tick();
        check_eq("busy_rdy_t1", {31'd0, bus_ready}, 32'd0);
        tick();
        bus_start_op = 1'b0;
        check_eq("busy_rdy_t2", {31'd0, bus_ready}, 32'd0);
        tick();
        check_eq("busy_rdy_t3", {31'd0, bus_ready}, 32'd1);
        pop_check("busy_data");
        tick();
        check_eq("busy_not_queued", {31'd0, bus_ready}, 32'd1);

        // start_op held for 9 edges: exactly 3 reads.
        ops = 0;
        prev_rdy = bus_ready;
        bus_start_op = 1'b1;
        repeat (3) push_read(32'd3, 9'h1FF);
        for (int i = 0; i < 12; i++) begin
            if (i == 9) bus_start_op = 1'b0;
            tick();
            if (prev_rdy && !bus_ready) ops++;
            if (!prev_rdy && bus_ready) pop_check("b2b_data");
            prev_rdy = bus_ready;
        end
        bus_start_op = 1'b0;
        check_eq("b2b_ops", ops, 32'd3);
        check_eq("b2b_sb_empty", exp_q.size(), 32'd0);

        // Out of range: dropped write, zero read, no aliasing, sticky error.
        do_op("wr_oor", 1'b1, 32'd64, 9'h000, 8'h55);
        check_eq("oor_range_err", {31'd0, range_err}, 32'd1);
        do_op("rd_oor", 1'b0, 32'd64, 9'h000, 8'h00);
        do_op("rd_lba0", 1'b0, 32'd0, 9'h000, 8'h00);
        do_op("wr_oor_hi", 1'b1, 32'h4000_0003, 9'h1FF, 8'hEE);
        do_op("rd_no_alias", 1'b0, 32'd3, 9'h1FF, 8'h00);
        check_eq("oor_sticky", {31'd0, range_err}, 32'd1);
        apply_reset(1);
        check_eq("oor_cleared", {31'd0, range_err}, 32'd0);

`ifdef RAMDISK_WRITE_PROTECT_EN
        do_op("wr_lba2", 1'b1, 32'd2, 9'h000, 8'h22);
        write_protect = 1'b1;
        bus_address  = {32'd2, 9'h000};
        bus_rw       = 1'b1;
        tb_wdata     = 8'h77;
        bus_start_op = 1'b1;
        tick();
        bus_start_op = 1'b0;
        repeat (2) tick();
        write_protect = 1'b0;
        check_eq("wp_hits", {16'd0, wp_hits}, 32'd1);
        do_op("wp_rd_lba2", 1'b0, 32'd2, 9'h000, 8'h00);
`endif

        // Reset during ACCESS of a write: the write must not land.
        do_op("wr_lba1", 1'b1, 32'd1, 9'h005, 8'h96);
        bus_address  = {32'd1, 9'h005};
        bus_rw       = 1'b1;
        tb_wdata     = 8'h3C;
        bus_start_op = 1'b1;
        tick();
        bus_start_op = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        bus_rw = 1'b0;
        check_eq("midrst_ready", {31'd0, bus_ready}, 32'd1);
        do_op("midrst_rd", 1'b0, 32'd1, 9'h005, 8'h00);

        // Activity: 8 cycles high after one op, retriggered by a second op.
        apply_reset(1);
        repeat (2) tick();
        check_eq("act_idle", {31'd0, activity}, 32'd0);
        do_op("act_op1", 1'b0, 32'd0, 9'h000, 8'h00);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (activity) hi++;
            tick();
        end
        check_eq("act_one_op", hi, 32'd8);
        do_op("act_op2a", 1'b0, 32'd0, 9'h000, 8'h00);
        act_min = activity;
        repeat (2) begin
            tick();
            act_min = act_min & activity;
        end
        do_op("act_op2b", 1'b0, 32'd0, 9'h000, 8'h00);
        act_min = act_min & activity;
        check_eq("act_held", {31'd0, act_min}, 32'd1);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (activity) hi++;
            tick();
        end
        check_eq("act_retrigger", hi, 32'd8);
        check_eq("sb_final_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Overall time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, required completion");
        $fatal(1, "timeout");
    end

endmodule
